sysarr_output_collector: RTL and testbench

// - Downstream of the systolic array: captures result rows (out_en/row_out/array_output) into a

---
 rtl/sys_arr_pkg.sv | 15 +
 rtl/sysarr_tile_bank.sv | 64 ++++++
 rtl/sysarr_output_collector.sv | 122 ++++++++++++
 tb/tb_sysarr_output_collector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared constants and types for the systolic-array output collector.
package sys_arr_pkg;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = $clog2(N);

    typedef logic [DW*N-1:0] row_t;
    typedef logic [RW-1:0]   ridx_t;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_SEND = 1'b1
    } wb_state_t;
endpackage

// File: rtl/sysarr_tile_bank.sv
// One NxN tile store: single write port, async read port, per-row valid mask and full flag.
module sysarr_tile_bank
    import sys_arr_pkg::*;
(
    input  logic          clk,
    input  logic          nRST,
    input  logic          wr_en_i,
    input  ridx_t         wr_row_i,
    input  row_t          wr_data_i,
    input  logic [AW-1:0] base_i,
    input  logic          free_i,
    input  ridx_t         rd_row_i,
    output row_t          rd_data_o,
    output logic [AW-1:0] base_o,
    output logic          full_o,
    output logic          dup_o,
    output logic          fill_o
);
    row_t          mem_q [N];
    logic [AW-1:0] base_q;
    logic [N-1:0]  mask_q, mask_d;
    logic          full_q, full_d;
    logic [N-1:0]  row_bit;

    always_comb begin
        row_bit = N'(1) << wr_row_i;
        dup_o   = mask_q[wr_row_i];
        fill_o  = &(mask_q | row_bit);
        mask_d  = mask_q;
        full_d  = full_q;
        // The mask is cleared the moment the tile completes, so the bank is ready to refill once freed.
        if (wr_en_i) begin
            if (fill_o) begin
                mask_d = '0;
                full_d = 1'b1;
            end else begin
                mask_d = mask_q | row_bit;
            end
        end
        if (free_i) full_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mask_q <= '0;
            full_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            full_q <= full_d;
        end
    end

    // Storage is data-only; validity is carried entirely by mask_q/full_q.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_data_i;
            if (mask_q == '0) base_q <= base_i;
        end
    end

    assign rd_data_o = mem_q[rd_row_i];
    assign base_o    = base_q;
    assign full_o    = full_q;
endmodule

// File: rtl/sysarr_output_collector.sv
// Captures array result rows into two ping-pong tile banks and drains full tiles to the scratchpad.
module sysarr_output_collector
    import sys_arr_pkg::*;
(
    input  logic          clk,
    input  logic          nRST,
    input  logic          out_en,
    input  ridx_t         row_out,
    input  logic [DW*N-1:0] array_output,
    input  logic [AW-1:0] tile_base,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [AW-1:0] wb_addr,
    output logic [DW*N-1:0] wb_data,
    output logic          wb_last,
    output logic          stall_sa,
    output logic          tile_done,
    output logic          err_dup
);
    localparam ridx_t LAST = ridx_t'(N - 1);

    logic [1:0]    wr_en, free, full, dup, fill;
    row_t          rd_data [2];
    logic [AW-1:0] base    [2];

    logic          fill_ptr_q, fill_ptr_d;
    logic          drain_ptr_q, drain_ptr_d;
    wb_state_t     state_q, state_d;
    ridx_t         r_q, r_d;
    logic          tile_done_q, tile_done_d;
    logic          err_dup_q, err_dup_d;
    logic          cap, complete, send, hs, other, here_ready, other_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sysarr_tile_bank u_bank (
            .clk       (clk),
            .nRST      (nRST),
            .wr_en_i   (wr_en[b]),
            .wr_row_i  (row_out),
            .wr_data_i (array_output),
            .base_i    (tile_base),
            .free_i    (free[b]),
            .rd_row_i  (r_q),
            .rd_data_o (rd_data[b]),
            .base_o    (base[b]),
            .full_o    (full[b]),
            .dup_o     (dup[b]),
            .fill_o    (fill[b])
        );
    end

    // Capture side
    always_comb begin
        stall_sa    = full[fill_ptr_q];
        cap         = out_en && !stall_sa;
        complete    = cap && fill[fill_ptr_q];
        wr_en       = '0;
        wr_en[fill_ptr_q] = cap;
        fill_ptr_d  = complete ? ~fill_ptr_q : fill_ptr_q;
        tile_done_d = complete;
        err_dup_d   = (out_en && stall_sa) || (cap && dup[fill_ptr_q]);
    end

    // Drain side; a tile completing this cycle counts as ready so write-back starts next cycle.
    always_comb begin
        send        = (state_q == WB_SEND);
        hs          = send && wb_ready;
        other       = ~drain_ptr_q;
        here_ready  = full[drain_ptr_q] || (complete && (fill_ptr_q == drain_ptr_q));
        other_ready = full[other] || (complete && (fill_ptr_q == other));
        state_d     = state_q;
        r_d         = r_q;
        drain_ptr_d = drain_ptr_q;
        free        = '0;
        case (state_q)
            WB_IDLE: begin
                if (here_ready) begin
                    state_d = WB_SEND;
                    r_d     = '0;
                end
            end
            WB_SEND: begin
                if (hs) begin
                    r_d = r_q + 1'b1;
                    if (r_q == LAST) begin
                        free[drain_ptr_q] = 1'b1;
                        drain_ptr_d       = other;
                        r_d               = '0;
                        state_d           = other_ready ? WB_SEND : WB_IDLE;
                    end
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            state_q     <= WB_IDLE;
            r_q         <= '0;
            tile_done_q <= 1'b0;
            err_dup_q   <= 1'b0;
        end else begin
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            state_q     <= state_d;
            r_q         <= r_d;
            tile_done_q <= tile_done_d;
            err_dup_q   <= err_dup_d;
        end
    end

    // Address/data are forced to zero outside SEND so nothing stale is visible after reset.
    assign wb_valid  = send;
    assign wb_addr   = send ? (base[drain_ptr_q] + AW'(r_q)) : '0;
    assign wb_data   = send ? rd_data[drain_ptr_q] : '0;
    assign wb_last   = send && (r_q == LAST);
    assign tile_done = tile_done_q;
    assign err_dup   = err_dup_q;
endmodule

// File: tb/tb_sysarr_output_collector.sv
// Scoreboard bench for sysarr_output_collector: directed tiles, backpressure, duplicates, reset.
module tb_sysarr_output_collector;
    import sys_arr_pkg::*;

    logic          clk = 1'b0;
    logic          nRST = 1'b0;
    logic          out_en = 1'b0;
    ridx_t         row_out = '0;
    row_t          array_output = '0;
    logic [AW-1:0] tile_base = '0;
    logic          wb_ready = 1'b1;
    logic          wb_valid, wb_last, stall_sa, tile_done, err_dup;
    logic [AW-1:0] wb_addr;
    row_t          wb_data;

    typedef struct {
        logic [AW-1:0] a;
        row_t          d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int td_cnt = 0;
    int dup_cnt = 0;

    sysarr_output_collector dut (
        .clk          (clk),
        .nRST         (nRST),
        .out_en       (out_en),
        .row_out      (row_out),
        .array_output (array_output),
        .tile_base    (tile_base),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_last      (wb_last),
        .stall_sa     (stall_sa),
        .tile_done    (tile_done),
        .err_dup      (err_dup)
    );

    always #5 clk = ~clk;

    function automatic row_t mkrow(int t, int r);
        row_t v;
        for (int e = 0; e < N; e++) v[(N-1-e)*DW +: DW] = 16'(t*256 + r*16 + e);
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(logic [AW-1:0] a, row_t d, logic l);
        exp_t e;
        e.a = a; e.d = d; e.l = l;
        q.push_back(e);
    endtask

    task automatic push_tile(logic [AW-1:0] b, int t);
        for (int r = 0; r < N; r++) push(b + AW'(r), mkrow(t, r), r == N-1);
    endtask

    task automatic send_row(int r, row_t d);
        out_en = 1'b1;
        row_out = ridx_t'(r);
        array_output = d;
        @(posedge clk); #1;
        out_en = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, "_wb_last"},  64'(wb_last),  64'd0);
        chk({tag, "_stall_sa"}, 64'(stall_sa), 64'd0);
        chk({tag, "_tile_done"},64'(tile_done),64'd0);
        chk({tag, "_err_dup"},  64'(err_dup),  64'd0);
        chk({tag, "_wb_addr"},  64'(wb_addr),  64'd0);
        chk({tag, "_wb_data"},  wb_data,       64'd0);
    endtask

    // Monitor: pulse counters, hold-stability check, scoreboard pop on every handshake.
    logic          prev_hold = 1'b0;
    logic [AW-1:0] prev_a;
    row_t          prev_d;
    always @(negedge clk) begin
        if (!nRST) begin
            prev_hold = 1'b0;
        end else begin
            if (tile_done) td_cnt++;
            if (err_dup) dup_cnt++;
            if (prev_hold) begin
                chk("hold_stable", {wb_valid, 15'd0, wb_addr, 32'd0} ^ 64'(wb_data != prev_d),
                    {1'b1, 15'd0, prev_a, 32'd0});
            end
            if (wb_valid && wb_ready) begin
                if (q.size() == 0) begin
                    chk("wb_unexpected", 64'(wb_addr), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("wb_addr", 64'(wb_addr), 64'(e.a));
                    chk("wb_data", wb_data, e.d);
                    chk("wb_last", 64'(wb_last), 64'(e.l));
                end
            end
            prev_hold = wb_valid && !wb_ready;
            prev_a    = wb_addr;
            prev_d    = wb_data;
        end
    end

    initial begin
        int td0, dup0;
        #3;
        chk_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;
        idle(1);

        // In-order tile
        td0 = td_cnt; dup0 = dup_cnt;
        tile_base = 16'h0040;
        push_tile(16'h0040, 1);
        for (int r = 0; r < N; r++) send_row(r, mkrow(1, r));
        wait_empty();
        idle(1);
        chk("t1_tile_done", 64'(td_cnt - td0), 64'd1);
        chk("t1_err_dup", 64'(dup_cnt - dup0), 64'd0);

        // Out-of-order rows 2,0,3,1
        td0 = td_cnt;
        tile_base = 16'h0080;
        push_tile(16'h0080, 2);
        send_row(2, mkrow(2, 2));
        send_row(0, mkrow(2, 0));
        send_row(3, mkrow(2, 3));
        idle(2);
        chk("t2_no_early_done", 64'(td_cnt - td0), 64'd0);
        send_row(1, mkrow(2, 1));
        wait_empty();
        idle(1);
        chk("t2_tile_done", 64'(td_cnt - td0), 64'd1);

        // Two tiles with backpressure, then release
        td0 = td_cnt; dup0 = dup_cnt;
        wb_ready = 1'b0;
        tile_base = 16'h0010;
        push_tile(16'h0010, 3);
        for (int r = 0; r < N; r++) send_row(r, mkrow(3, r));
        tile_base = 16'h0020;
        push_tile(16'h0020, 4);
        for (int r = 0; r < N; r++) send_row(r, mkrow(4, r));
        idle(1);
        @(negedge clk);
        chk("t3_tile_done", 64'(td_cnt - td0), 64'd2);
        chk("t3_stall_on", 64'(stall_sa), 64'd1);
        #4;
        tile_base = 16'h0099;
        send_row(0, mkrow(9, 0));
        idle(2);
        chk("t3_drop_err_dup", 64'(dup_cnt - dup0), 64'd1);
        chk("t3_stall_held", 64'(stall_sa), 64'd1);
        wb_ready = 1'b1;
        for (int k = 0; k < 2*N; k++) begin
            @(negedge clk);
            chk("t3_no_bubble", 64'(wb_valid), 64'd1);
            chk("t3_stall_seq", 64'(stall_sa), 64'(k < N));
        end
        wait_empty();
        idle(2);
        chk("t3_no_extra_done", 64'(td_cnt - td0), 64'd2);

        // Duplicate row 1
        td0 = td_cnt; dup0 = dup_cnt;
        tile_base = 16'h0030;
        push(16'h0030, mkrow(5, 0), 1'b0);
        push(16'h0031, mkrow(6, 1), 1'b0);
        push(16'h0032, mkrow(5, 2), 1'b0);
        push(16'h0033, mkrow(5, 3), 1'b1);
        send_row(0, mkrow(5, 0));
        send_row(1, mkrow(5, 1));
        send_row(1, mkrow(6, 1));
        send_row(2, mkrow(5, 2));
        send_row(3, mkrow(5, 3));
        wait_empty();
        idle(1);
        chk("t4_err_dup", 64'(dup_cnt - dup0), 64'd1);
        chk("t4_tile_done", 64'(td_cnt - td0), 64'd1);

        // Toggling wb_ready
        wb_ready = 1'b0;
        tile_base = 16'h0050;
        push_tile(16'h0050, 7);
        for (int r = 0; r < N; r++) send_row(r, mkrow(7, r));
        for (int k = 0; k < 20; k++) begin
            wb_ready = ~wb_ready;
            idle(1);
        end
        wb_ready = 1'b1;
        wait_empty();

        // Reset after a partial tile
        tile_base = 16'h0060;
        send_row(0, mkrow(8, 0));
        send_row(1, mkrow(8, 1));
        nRST = 1'b0;
        #2;
        chk_reset_outputs("rst1");
        @(posedge clk); #1;
        nRST = 1'b1;
        idle(1);
        td0 = td_cnt;
        tile_base = 16'h0070;
        push_tile(16'h0070, 10);
        for (int r = 0; r < N; r++) send_row(r, mkrow(10, r));
        wait_empty();
        idle(2);
        chk("t6_tile_done", 64'(td_cnt - td0), 64'd1);
        chk("t6_idle_valid", 64'(wb_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
